jk_down_counter: RTL and testbench
==================================

Name: jk_down_counter

Overview:
- Synchronous binary down counter built from JK flip-flop cells: the count-down counterpart of the team's 4-bit JK up counter.
- Adds parallel load, count enable, an auto-reload mode for use as a programmable divider/timer, and zero/borrow flags.
- Sits alongside the up counter in the lab counter set; the testbench drives it from a free-running clock.

Parameters:
- WIDTH, 4, number of counter bits (>=2).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- en  input  1  count enable; decrements by 1 per clk edge when high
- load  input  1  synchronous parallel load of d; has priority over en
- auto_reload  input  1  when 1, an enabled count from 0 loads d instead of wrapping
- d  input  WIDTH  load/reload value
- q  output  WIDTH  current count
- zero  output  1  combinational; 1 when q == 0
- borrow  output  1  combinational; en & ~load & zero (the next edge underflows)

Behaviour:
- Reset: rst high forces q = 0 immediately, independent of clk.
  - While rst is high: zero = 1; borrow = en & ~load.
  - On release, counting resumes at the first rising clk edge with rst low.
  - Reset asserted mid-count aborts the count; no partial state survives.
- Each bit is one JK cell. All cells share clk and rst; no ripple clocking.
- Priority on each rising edge with rst low:
  1. load=1 -> q <= d. Each cell gets J=d[i], K=~d[i].
  2. en=1, zero=1, auto_reload=1 -> q <= d. This is the reload, with the same JK drive as load.
  3. en=1 otherwise -> q <= q - 1 mod 2^WIDTH.
     - Cell i gets J=K=1 when all lower bits q[i-1:0] are 0.
     - Cell 0 always toggles.
  4. en=0 -> hold, J=K=0.
- Wrap-around: with auto_reload=0, q=0 and en=1 gives q = 2^WIDTH-1 on the next edge. borrow is high during the cycle before that edge.
- Reload with d=0: q stays 0. zero stays 1 and borrow stays 1 every enabled cycle, a degenerate divide-by-1.
- Divider period with auto_reload=1 and en held high: borrow pulses once every d+1 cycles (d>0).
- load and en both high: load wins; no decrement that cycle.
- Latency: q updates on the same edge as the command. zero and borrow follow q combinationally, with no added cycle.
- No X on any output after reset. Inputs are sampled only at rising clk edges.

Decomposition:
- Shared package jk_pkg holds the JK command constants:
  - JK_HOLD = 2'b00
  - JK_RST = 2'b01
  - JK_SET = 2'b10
  - JK_TOG = 2'b11
  - These are shared with the up counter.
- Sub-module jk_ff_ar: a single JK flip-flop with asynchronous active-high reset to 0.
  - Ports: clk, rst, j, k, q.
  - Replaces the reset-less JK cell for this block.
- Top level: a generate loop of WIDTH cells, plus the per-bit J/K select mux (load/reload vs toggle-chain vs hold) and the zero/borrow logic.

Test Plan:
- Reset: assert rst mid-cycle with q=9 -> q=0 and zero=1 before the next clk edge; hold rst 3 edges -> q stays 0.
- Free count down: after reset, en=1, auto_reload=0, WIDTH=4 for 18 edges -> q sequence 15,14,...,0,15,14; borrow high exactly in the cycles where q=0.
- Load priority: q=6, load=1, en=1, d=11 -> next q=11; then load=0 -> q=10,9.
- Hold: en=0 for 5 edges at q=3 -> q stays 3; zero=0, borrow=0.
- Auto-reload divider: d=4, auto_reload=1, en=1 from q=0 -> q cycles 4,3,2,1,0,4,...; borrow period exactly 5 cycles.
- Edge cases:
  - d=0 with auto_reload=1 -> q pinned at 0, borrow constantly 1.
  - rst asserted during a reload edge -> q=0, no reload applied.

Source files
------------

// File: rtl/jk_pkg.sv
// jk_pkg: JK command encodings and next-state helper shared by the JK counters
package jk_pkg;
  typedef logic [1:0] jk_cmd_t;
  localparam jk_cmd_t JK_HOLD = 2'b00;
  localparam jk_cmd_t JK_RST  = 2'b01;
  localparam jk_cmd_t JK_SET  = 2'b10;
  localparam jk_cmd_t JK_TOG  = 2'b11;
  function automatic logic jk_next(input logic q, input jk_cmd_t cmd);
    return cmd == JK_SET ? 1'b1 :
           cmd == JK_RST ? 1'b0 :
           cmd == JK_TOG ? ~q : q;
  endfunction
endpackage

// File: rtl/jk_ff_ar.sv
// jk_ff_ar: JK flip-flop with asynchronous active-high reset to 0
module jk_ff_ar
  import jk_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= 1'b0;
    else q <= jk_next(q, {j, k});
endmodule

// File: rtl/jk_down_counter.sv
// jk_down_counter: synchronous JK down counter with load, enable, auto-reload and zero/borrow flags
module jk_down_counter
  import jk_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             zero,
  output logic             borrow
);
  logic [WIDTH-1:0] lower_zero;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             reload;
  assign zero   = ~|q;
  assign borrow = en & ~load & zero;
  assign reload = load | (en & zero & auto_reload);
  assign lower_zero[0] = 1'b1;
  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_cell
      // a bit toggles on decrement only when every lower bit is 0 (borrow propagates)
      if (i > 0) begin : g_chain
        assign lower_zero[i] = lower_zero[i-1] & ~q[i-1];
      end
      assign j[i] = reload ? d[i]  : en & lower_zero[i];
      assign k[i] = reload ? ~d[i] : en & lower_zero[i];
      jk_ff_ar u_ff (
        .clk(clk),
        .rst(rst),
        .j  (j[i]),
        .k  (k[i]),
        .q  (q[i])
      );
    end
  endgenerate
endmodule

// File: tb/tb_jk_down_counter.sv
// tb_jk_down_counter: directed self-checking bench for the JK down counter
module tb_jk_down_counter;
  logic       clk = 1'b0;
  logic       rst, en, load, auto_reload;
  logic [3:0] d;
  logic [3:0] q;
  logic       zero, borrow;
  int checks = 0;
  int errors = 0;

  jk_down_counter #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .auto_reload(auto_reload),
    .d(d), .q(q), .zero(zero), .borrow(borrow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int e;
    int last;
    rst = 1'b1; en = 1'b0; load = 1'b0; auto_reload = 1'b0; d = 4'd0;
    tick(); tick();
    chk("reset_q", q, 0);
    chk("reset_zero", zero, 1);
    chk("reset_borrow_en0", borrow, 0);
    en = 1'b1; #1;
    chk("reset_borrow_en1", borrow, 1);
    en = 1'b0;
    // load 9, then assert reset asynchronously mid-cycle
    rst = 1'b0; load = 1'b1; d = 4'd9;
    tick();
    chk("load9_q", q, 9);
    chk("load9_zero", zero, 0);
    load = 1'b0;
    #3 rst = 1'b1;
    #1;
    chk("async_rst_q", q, 0);
    chk("async_rst_zero", zero, 1);
    for (int n = 0; n < 3; n++) begin
      tick();
      chk("rst_hold_q", q, 0);
    end
    // free count down with wrap
    rst = 1'b0; en = 1'b1; e = 0;
    for (int n = 0; n < 18; n++) begin
      #1;
      chk("free_borrow", borrow, (e == 0) ? 1 : 0);
      tick();
      e = (e + 15) % 16;
      chk("free_q", q, e);
    end
    chk("free_end_q", q, 14);
    // load priority over enable
    en = 1'b0; load = 1'b1; d = 4'd6;
    tick();
    chk("prio_pre_q", q, 6);
    en = 1'b1; d = 4'd11;
    tick();
    chk("prio_load_q", q, 11);
    load = 1'b0;
    tick();
    chk("prio_dec1_q", q, 10);
    tick();
    chk("prio_dec2_q", q, 9);
    // hold
    en = 1'b0; load = 1'b1; d = 4'd3;
    tick();
    load = 1'b0;
    for (int n = 0; n < 5; n++) begin
      tick();
      chk("hold_q", q, 3);
      chk("hold_zero", zero, 0);
      chk("hold_borrow", borrow, 0);
    end
    // auto-reload divider, d=4
    load = 1'b1; d = 4'd0;
    tick();
    chk("ar_start_q", q, 0);
    load = 1'b0; d = 4'd4; auto_reload = 1'b1; en = 1'b1;
    e = 0; last = -1;
    for (int n = 0; n < 16; n++) begin
      #1;
      chk("ar_borrow", borrow, (e == 0) ? 1 : 0);
      if (borrow) begin
        if (last >= 0) chk("ar_period", n - last, 5);
        last = n;
      end
      tick();
      e = (e == 0) ? 4 : e - 1;
      chk("ar_q", q, e);
    end
    // degenerate reload with d=0
    en = 1'b0; load = 1'b1; d = 4'd0;
    tick();
    load = 1'b0; en = 1'b1;
    for (int n = 0; n < 5; n++) begin
      #1;
      chk("d0_borrow", borrow, 1);
      tick();
      chk("d0_q", q, 0);
      chk("d0_zero", zero, 1);
    end
    // reset held across a reload edge
    d = 4'd7;
    #1 rst = 1'b1;
    tick();
    chk("rst_reload_q", q, 0);
    rst = 1'b0;
    tick();
    chk("post_rst_reload_q", q, 7);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
